// File: rtl/cmp_pkg.sv
// Shared definitions for the cmp_arbiter compare sequencer: op codes, FSM encoding, width.
package cmp_pkg;

   localparam int unsigned CMP_WIDTH = 32;

   localparam logic [2:0] OP_SLT  = 3'b000;
   localparam logic [2:0] OP_SGT  = 3'b001;
   localparam logic [2:0] OP_SEQ  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_SLTU = 3'b100;
   localparam logic [2:0] OP_SGTU = 3'b101;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/cmp_arbiter_core.sv
// Combinational compare datapath: one subtractor, signed overflow and optional borrow.
// Unsigned compares are built only when CMP_UNSIGNED_EN is defined.
module cmp_core
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH = CMP_WIDTH
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] res
);

   logic [WIDTH-1:0] z;
   logic             ovf;
   logic             slt;
`ifdef CMP_UNSIGNED_EN
   logic [WIDTH:0]   diff;
   logic             borrow;
`endif

   always_comb begin
`ifdef CMP_UNSIGNED_EN
      // Zero-extended subtract: the extra MSB is the borrow (inverted carry-out).
      diff   = {1'b0, x} - {1'b0, y};
      z      = diff[WIDTH-1:0];
      borrow = diff[WIDTH];
`else
      z      = x - y;
`endif
      ovf = (x[WIDTH-1] ^ y[WIDTH-1]) & (z[WIDTH-1] ^ x[WIDTH-1]);
      slt = z[WIDTH-1] ^ ovf;

      res = '0;
      case (op)
         OP_SLT, OP_SGT:   res = WIDTH'(slt);
         OP_SEQ:           res = WIDTH'(z == '0);
         OP_SUB:           res = z;
`ifdef CMP_UNSIGNED_EN
         OP_SLTU, OP_SGTU: res = WIDTH'(borrow);
`else
         OP_SLTU, OP_SGTU: res = WIDTH'(slt);
`endif
         default:          res = '0;
      endcase
   end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter and IDLE/EXEC/DONE sequencer for the shared compare unit.
// Optional unsigned compares: define CMP_UNSIGNED_EN.
module cmp_arbiter
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH = CMP_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic [2:0]       r0_op,
   input  logic [WIDTH-1:0] r0_a,
   input  logic [WIDTH-1:0] r0_b,
   output logic             r0_rvalid,
   input  logic             r0_rready,
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic [2:0]       r1_op,
   input  logic [WIDTH-1:0] r1_a,
   input  logic [WIDTH-1:0] r1_b,
   output logic             r1_rvalid,
   input  logic             r1_rready,
   output logic [WIDTH-1:0] rdata
);

   logic [1:0]       state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             own_q, own_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]       rvalid_q, rvalid_d;

   logic             gnt0, gnt1, swap;
   logic [WIDTH-1:0] core_x, core_y, core_res;

   // SGT/SGTU reuse the less-than datapath on swapped operands.
   assign swap   = (op_q[1:0] == 2'b01);
   assign core_x = swap ? b_q : a_q;
   assign core_y = swap ? a_q : b_q;

   cmp_core #(.WIDTH(WIDTH)) u_core (
      .x   (core_x),
      .y   (core_y),
      .op  (op_q),
      .res (core_res)
   );

   // ptr_q holds the last served requester; on a tie the other one wins.
   assign gnt0 = r0_valid & (~r1_valid | ptr_q);
   assign gnt1 = r1_valid & (~r0_valid | ~ptr_q);

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      own_d    = own_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      rdata_d  = rdata_q;
      rvalid_d = rvalid_q;
      r0_ready = 1'b0;
      r1_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            r0_ready = ~rst & gnt0;
            r1_ready = ~rst & gnt1;
            if (gnt0 | gnt1) begin
               own_d   = gnt1;
               a_d     = gnt1 ? r1_a  : r0_a;
               b_d     = gnt1 ? r1_b  : r0_b;
               op_d    = gnt1 ? r1_op : r0_op;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rdata_d  = core_res;
            ptr_d    = own_q;
            rvalid_d = own_q ? 2'b10 : 2'b01;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            if (own_q ? r1_rready : r0_rready) begin
               rvalid_d = 2'b00;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ptr_q    <= 1'b1;
         own_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= 3'b000;
         rdata_q  <= '0;
         rvalid_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         own_q    <= own_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign r0_rvalid = rvalid_q[0];
   assign r1_rvalid = rvalid_q[1];
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed self-checking bench for cmp_arbiter (either CMP_UNSIGNED_EN setting).
module tb_cmp_arbiter;
   import cmp_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_valid, r0_ready, r0_rvalid, r0_rready;
   logic        r1_valid, r1_ready, r1_rvalid, r1_rready;
   logic [2:0]  r0_op, r1_op;
   logic [31:0] r0_a, r0_b, r1_a, r1_b, rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cmp_arbiter #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .r0_valid  (r0_valid),
      .r0_ready  (r0_ready),
      .r0_op     (r0_op),
      .r0_a      (r0_a),
      .r0_b      (r0_b),
      .r0_rvalid (r0_rvalid),
      .r0_rready (r0_rready),
      .r1_valid  (r1_valid),
      .r1_ready  (r1_ready),
      .r1_op     (r1_op),
      .r1_a      (r1_a),
      .r1_b      (r1_b),
      .r1_rvalid (r1_rvalid),
      .r1_rready (r1_rready),
      .rdata     (rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op from requester id while the DUT is IDLE; called at a negedge.
   task automatic run_op(input int id, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input string tag);
      if (id == 0) begin
         r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b;
      end else begin
         r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b;
      end
      #1;
      chk({tag, "_ready"}, 32'(id == 0 ? r0_ready : r1_ready), 32'd1);
      @(negedge clk);
      r0_valid = 1'b0; r1_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_rvalid"}, 32'(id == 0 ? r0_rvalid : r1_rvalid), 32'd1);
      chk(tag, rdata, exp);
      if (id == 0) r0_rready = 1'b1; else r1_rready = 1'b1;
      @(negedge clk);
      r0_rready = 1'b0; r1_rready = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_sltu, exp_sgtu;
      rst = 1'b1;
      r0_valid = 1'b1; r0_op = OP_SLT; r0_a = 32'd5; r0_b = 32'hFFFF_FFFF; r0_rready = 1'b0;
      r1_valid = 1'b0; r1_op = OP_SLT; r1_a = '0;    r1_b = '0;           r1_rready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_r0_ready", 32'(r0_ready), 32'd0);
      chk("rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
      chk("rst_r1_rvalid", 32'(r1_rvalid), 32'd0);
      chk("rst_rdata", rdata, 32'd0);

      // Lone request right out of reset, result held under backpressure.
      rst = 1'b0;
      #1;
      chk("lone_r0_ready", 32'(r0_ready), 32'd1);
      chk("lone_r1_ready", 32'(r1_ready), 32'd0);
      @(negedge clk);
      r0_valid = 1'b0;
      chk("exec_r0_ready", 32'(r0_ready), 32'd0);
      chk("exec_r0_rvalid", 32'(r0_rvalid), 32'd0);
      @(negedge clk);
      chk("lone_rvalid", 32'(r0_rvalid), 32'd1);
      chk("lone_rdata", rdata, 32'd0);
      r1_valid = 1'b1; r1_op = OP_SUB; r1_a = 32'h8000_0000; r1_b = 32'd1;
      r1_rready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         r1_rready = 1'b0;
         chk("hold_rvalid", 32'(r0_rvalid), 32'd1);
         chk("hold_rdata", rdata, 32'd0);
         chk("hold_r1_ready", 32'(r1_ready), 32'd0);
         chk("hold_r1_rvalid", 32'(r1_rvalid), 32'd0);
      end
      r0_rready = 1'b1;
      @(negedge clk);
      r0_rready = 1'b0;
      chk("release_rvalid", 32'(r0_rvalid), 32'd0);
      // r1 has been waiting; it is now the only valid requester.
      r1_valid = 1'b0;
      run_op(1, OP_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, "sub_wrap");

      run_op(0, OP_SGT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1, "sgt_ovf");
      run_op(0, OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, "slt_ovf");
      run_op(1, OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, "slt_neg");
      run_op(0, OP_SEQ, 32'h1234, 32'h1234, 32'd1, "seq_eq");
      run_op(1, OP_SEQ, 32'h1234, 32'h1235, 32'd0, "seq_ne");
      run_op(0, OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, "sub_neg");
      run_op(1, 3'b110, 32'd5, 32'd3, 32'd0, "reserved");

`ifdef CMP_UNSIGNED_EN
      exp_sltu = 32'd1; exp_sgtu = 32'd0;
`else
      exp_sltu = 32'd0; exp_sgtu = 32'd1;
`endif
      run_op(0, OP_SLTU, 32'd1, 32'hFFFF_FFFF, exp_sltu, "sltu");
      run_op(1, OP_SGTU, 32'd1, 32'hFFFF_FFFF, exp_sgtu, "sgtu");
      run_op(0, OP_SUB, 32'd9, 32'd2, 32'd7, "sub_pre_rst");

      // Reset while EXEC: in-flight result abandoned, pointer back to favour r0.
      r1_valid = 1'b1; r1_op = OP_SUB; r1_a = 32'd100; r1_b = 32'd1;
      #1;
      chk("pre_rst_r1_ready", 32'(r1_ready), 32'd1);
      @(negedge clk);
      r1_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_exec_rvalid", 32'(r1_rvalid), 32'd0);
      chk("rst_exec_rdata", rdata, 32'd0);
      chk("rst_exec_state", 32'(dut.state_q), 32'(ST_IDLE));
      rst = 1'b0;

      // Both valid continuously, rready tied high: grants alternate every 3 cycles.
      r0_valid = 1'b1; r0_op = OP_SUB; r0_a = 32'd10;    r0_b = 32'd3;
      r1_valid = 1'b1; r1_op = OP_SEQ; r1_a = 32'h1234;  r1_b = 32'h1234;
      r0_rready = 1'b1; r1_rready = 1'b1;
      for (int g = 0; g < 4; g++) begin
         #1;
         chk("rr_r0_ready", 32'(r0_ready), 32'((g % 2) == 0));
         chk("rr_r1_ready", 32'(r1_ready), 32'((g % 2) == 1));
         @(negedge clk);
         chk("rr_exec_ready", 32'(r0_ready | r1_ready), 32'd0);
         @(negedge clk);
         chk("rr_r0_rvalid", 32'(r0_rvalid), 32'((g % 2) == 0));
         chk("rr_r1_rvalid", 32'(r1_rvalid), 32'((g % 2) == 1));
         chk("rr_rdata", rdata, ((g % 2) == 0) ? 32'd7 : 32'd1);
         @(negedge clk);
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
      r0_rready = 1'b0; r1_rready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Shared-compare sequencer for the MIPS32 datapath. Two requesters share one 32-bit subtractor-based compare unit: the ALU slt/sgt path (port 0) and the branch-resolve path (port 1). The block arbitrates round-robin, captures operands, runs the compare on a single registered subtract, and holds the result until the owning requester accepts it. It sits between the decode/issue stage and the shared subtractor instance.

## Interface

- Parameters
  - WIDTH, 32: operand and result width; only 32 is supported.
- Ports: one clock; reset is synchronous and active-high.
  - clk  in  1  system clock, rising edge.
  - rst  in  1  synchronous, active-high reset.
  - r0_valid / r1_valid  in  1  request valid, per requester.
  - r0_ready / r1_ready  out  1  request accepted this cycle.
  - r0_op / r1_op  in  3  operation code (see Operation).
  - r0_a, r0_b / r1_a, r1_b  in  32  operands.
  - r0_rvalid / r1_rvalid  out  1  result valid, owner only.
  - r0_rready / r1_rready  in  1  result accepted.
  - rdata  out  32  result, shared by both requesters; meaningful only while the owner's rvalid is high.

## Operation

- FSM states: IDLE, EXEC, DONE. Reset state is IDLE.
- IDLE
  - Grant goes to one valid requester. A lone requester wins.
  - If both are valid, the requester not served last wins.
  - The winner's ready is high combinationally, and only in IDLE.
  - On the valid & ready cycle: latch a, b, op and owner id, then go to EXEC.
- EXEC (exactly one cycle)
  - Operands are muxed into one subtractor: z = x − y, with x = a, y = b.
  - For SGT/SGTU the operands are swapped: x = b, y = a.
  - Result is registered into rdata. The serve pointer is set to the owner. Go to DONE.
- DONE
  - Owner's rvalid is high. rdata is held stable.
  - When the owner's rready is high, go to IDLE on the next edge.
  - The non-owner's rready is ignored.
- Ops (result occupies rdata[0]; rdata[31:1] = 0 unless stated):
  - 000 SLT: signed a<b, computed as z[31] XOR ovf. ovf = (x[31]≠y[31]) & (z[31]≠x[31]).
  - 001 SGT: signed a>b, same formula on the swapped operands.
  - 010 SEQ: z == 0.
  - 011 SUB: rdata = a − b, full 32 bits, wrap-around modulo 2^32, no trap.
  - 100 SLTU, 101 SGTU: see Configuration.
  - 11x: reserved; rdata = 0.
- Signed compare must be overflow-correct. Example: a = 0x7FFFFFFF, b = 0x80000000 gives SLT = 0 and SGT = 1.

## Timing

- Reset values: r0_ready/r1_ready = 0 (combinational, but forced 0 while rst), r0_rvalid/r1_rvalid = 0, rdata = 0, state = IDLE, serve pointer = 1 (so requester 0 wins the first tie).
- Latency: accept at edge N, result registered at N+1, rvalid visible in cycle N+1. Earliest next accept is the cycle after the rready handshake.
- Throughput: at most one op every 3 cycles with zero backpressure.
- Requests asserted in EXEC/DONE see ready = 0. They must hold valid and stable until accepted.
- rst asserted in any state: at the next edge go to IDLE, drop rvalid, abandon any in-flight result, reset the pointer.
- A requester whose result is in DONE may already assert its next valid; it cannot be accepted before IDLE.

## Configuration

- CMP_UNSIGNED_EN
  - Defined: 100 SLTU = unsigned a<b = NOT carry-out of a − b (borrow); 101 SGTU = unsigned a>b, computed on the swapped operands.
  - Undefined: op[2] is ignored for codes 100/101, which execute as SLT/SGT signed. No carry path is built.

## Structure

- Package cmp_pkg holds:
  - op code localparams: OP_SLT, OP_SGT, OP_SEQ, OP_SUB, OP_SLTU, OP_SGTU;
  - state encoding (IDLE, EXEC, DONE);
  - WIDTH default.
- One sub-module, cmp_core: purely combinational. Inputs x, y, op; outputs the 32-bit result. It contains the subtractor, the overflow/borrow logic and the result formatting.
- Arbiter, FSM and registers live in cmp_arbiter.

## Test plan

- Reset and lone request: after rst, r0 sends SLT a = 5, b = 0xFFFFFFFF → r0_ready in the same cycle; next cycle r0_rvalid = 1, rdata = 0. Hold r0_rready = 0 for 3 cycles → rdata stable, r1_ready = 0 throughout.
- Overflow: SGT a = 0x7FFFFFFF, b = 0x80000000 → rdata = 1. SLT with the same operands → 0. SUB 0x80000000 − 1 → 0x7FFFFFFF.
- Round-robin: r0 and r1 both valid continuously. Grants alternate r0, r1, r0, r1, spaced 3 cycles apart with rready tied high.
- SEQ and SUB: SEQ a = b = 0x1234 → 1. SUB 3 − 5 → 0xFFFFFFFE.
- With CMP_UNSIGNED_EN: SLTU a = 1, b = 0xFFFFFFFF → 1 (signed SLT gives 0). Without the macro, the same op gives 0.
- Reset in EXEC: rst asserted the cycle after accept → next cycle rvalid = 0, state IDLE, rdata = 0; simultaneous r0/r1 valid then grants r0.
